// File: rtl/line_pkg.sv
// Shared types for the line rasteriser, the animation datapath and the framebuffer.
package line_pkg;

    localparam int unsigned COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StDraw,
        StDone
    } state_t;

endpackage

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: one framebuffer pixel coordinate per clock, drawn from
// the lower-x endpoint upwards (in the transposed frame for steep lines).
module line_drawer
    import line_pkg::*;
#(
    parameter int unsigned COORD_W = line_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pixel_valid,
    output logic               busy,
    output logic               done
);

    state_t state_q;

    // Endpoints latched on acceptance; later input changes are ignored.
    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;

    // Running point in the (possibly transposed) frame.
    logic [COORD_W-1:0] cx_q, cy_q, xend_q;
    logic signed [COORD_W:0] dx_q, dy_q, err_q;
    logic ystep_neg_q;
    logic steep_q;

    // Setup results, derived combinationally from the latched endpoints.
    logic [COORD_W-1:0] adx, ady;
    logic [COORD_W-1:0] tx0, ty0, tx1, ty1;
    logic [COORD_W-1:0] sx0, sy0, sx1, sy1;
    logic               steep;
    logic signed [COORD_W:0] dx_s, dy_s, err_s;
    logic               ystep_neg_s;

    // Draw-step results for the next pixel.
    logic [COORD_W-1:0] nx, ny;
    logic signed [COORD_W:0] err_add, err_nx;

    // Setup: steepness test, transpose, order by x, deltas and initial error.
    always_comb begin
        adx = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
        ady = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;
        steep = ady > adx;
        tx0 = steep ? y0_q : x0_q;
        ty0 = steep ? x0_q : y0_q;
        tx1 = steep ? y1_q : x1_q;
        ty1 = steep ? x1_q : y1_q;
        if (tx0 > tx1) begin
            sx0 = tx1;
            sy0 = ty1;
            sx1 = tx0;
            sy1 = ty0;
        end else begin
            sx0 = tx0;
            sy0 = ty0;
            sx1 = tx1;
            sy1 = ty1;
        end
        dx_s = $signed({1'b0, sx1 - sx0});
        dy_s = $signed({1'b0, (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1});
        ystep_neg_s = !(sy0 < sy1);
        err_s = '0 - (dx_s >>> 1);
    end

    // Draw step: advance the major axis, step the minor axis when error turns non-negative.
    always_comb begin
        nx = cx_q + 1'b1;
        err_add = err_q + dy_q;
        ny = cy_q;
        err_nx = err_add;
        if (!err_add[COORD_W]) begin
            ny = ystep_neg_q ? cy_q - 1'b1 : cy_q + 1'b1;
            err_nx = err_add - dx_q;
        end
    end

    // Control FSM with registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            xend_q      <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            ystep_neg_q <= 1'b0;
            steep_q     <= 1'b0;
            x           <= '0;
            y           <= '0;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        x0_q    <= x0;
                        y0_q    <= y0;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        busy    <= 1'b1;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    cx_q        <= sx0;
                    cy_q        <= sy0;
                    xend_q      <= sx1;
                    dx_q        <= dx_s;
                    dy_q        <= dy_s;
                    err_q       <= err_s;
                    ystep_neg_q <= ystep_neg_s;
                    steep_q     <= steep;
                    // First pixel is presented straight out of setup so there is no bubble.
                    x           <= steep ? sy0 : sx0;
                    y           <= steep ? sx0 : sy0;
                    pixel_valid <= 1'b1;
                    state_q     <= StDraw;
                end
                StDraw: begin
                    if (cx_q == xend_q) begin
                        pixel_valid <= 1'b0;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cx_q  <= nx;
                        cy_q  <= ny;
                        err_q <= err_nx;
                        x     <= steep_q ? ny : nx;
                        y     <= steep_q ? nx : ny;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: pixel sequences, latency, done/busy timing,
// back-to-back lines and mid-line reset.
module tb_line_drawer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [10:0] x, y;
    logic        pixel_valid, busy, done;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run_line.
    int px [0:511];
    int py [0:511];
    int n_pix;
    int first_cyc;
    bit done_after, done_next, busy_next, timed_out, busy_low_in_draw;

    line_drawer #(.COORD_W(11)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .x0(x0),
        .y0(y0),
        .x1(x1),
        .y1(y1),
        .x(x),
        .y(y),
        .pixel_valid(pixel_valid),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Pulse start for one line, scramble inputs after acceptance, capture the pixels.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1);
        bit started;
        n_pix = 0;
        first_cyc = -1;
        done_after = 0;
        done_next = 1;
        busy_next = 1;
        timed_out = 1;
        busy_low_in_draw = 0;
        started = 0;
        @(negedge clk);
        x0 = 11'(ax0);
        y0 = 11'(ay0);
        x1 = 11'(ax1);
        y1 = 11'(ay1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x0 = 11'd7;
        y0 = 11'd9;
        x1 = 11'd2;
        y1 = 11'd400;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (pixel_valid) begin
                if (n_pix < 512) begin
                    px[n_pix] = int'(x);
                    py[n_pix] = int'(y);
                end
                if (!started) first_cyc = cyc;
                if (!busy) busy_low_in_draw = 1;
                started = 1;
                n_pix++;
            end else if (started) begin
                done_after = done;
                @(negedge clk);
                done_next = done;
                busy_next = busy;
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (x !== 11'd0 || y !== 11'd0) begin
            errors++;
            $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", x, y);
        end
        checks++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got pv=%b busy=%b done=%b want 0,0,0",
                     pixel_valid, busy, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got pv=%b busy=%b want 0,0", pixel_valid, busy);
        end
    endtask

    task automatic test_horizontal();
        run_line(0, 0, 3, 0);
        checks++;
        if (timed_out || n_pix != 4) begin
            errors++;
            $display("FAIL horiz_count: got %0d pixels (timeout=%0b) want 4", n_pix, timed_out);
        end
        checks++;
        if (first_cyc != 2) begin
            errors++;
            $display("FAIL horiz_latency: first pixel at cycle %0d want 2", first_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (px[i] != i || py[i] != 0) begin
                errors++;
                $display("FAIL horiz_px%0d: got (%0d,%0d) want (%0d,0)", i, px[i], py[i], i);
            end
        end
        checks++;
        if (done_after !== 1'b1 || done_next !== 1'b0) begin
            errors++;
            $display("FAIL horiz_done: got done=%b then %b want 1 then 0", done_after, done_next);
        end
        checks++;
        if (busy_next !== 1'b0 || busy_low_in_draw) begin
            errors++;
            $display("FAIL horiz_busy: got busy_after=%b low_in_draw=%0b want 0,0",
                     busy_next, busy_low_in_draw);
        end
    endtask

    task automatic test_steep();
        int ex [0:3] = '{0, 1, 1, 1};
        int ey [0:3] = '{0, 1, 2, 3};
        run_line(0, 0, 1, 3);
        checks++;
        if (timed_out || n_pix != 4) begin
            errors++;
            $display("FAIL steep_count: got %0d pixels want 4 contiguous", n_pix);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (px[i] != ex[i] || py[i] != ey[i]) begin
                errors++;
                $display("FAIL steep_px%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, px[i], py[i], ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_reversed();
        run_line(3, 0, 0, 0);
        checks++;
        if (timed_out || n_pix != 4) begin
            errors++;
            $display("FAIL rev_count: got %0d pixels want 4", n_pix);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (px[i] != i || py[i] != 0) begin
                errors++;
                $display("FAIL rev_px%0d: got (%0d,%0d) want (%0d,0)", i, px[i], py[i], i);
            end
        end
    endtask

    task automatic test_degenerate();
        run_line(5, 5, 5, 5);
        checks++;
        if (timed_out || n_pix != 1) begin
            errors++;
            $display("FAIL degen_count: got %0d pixels want 1", n_pix);
        end
        checks++;
        if (px[0] != 5 || py[0] != 5) begin
            errors++;
            $display("FAIL degen_px: got (%0d,%0d) want (5,5)", px[0], py[0]);
        end
        checks++;
        if (done_after !== 1'b1) begin
            errors++;
            $display("FAIL degen_done: got %b want 1", done_after);
        end
    endtask

    task automatic test_datapath_line();
        bit mono_ok = 1;
        run_line(319, 0, 159, 150);
        checks++;
        if (timed_out || n_pix != 161) begin
            errors++;
            $display("FAIL dp_count: got %0d pixels want 161", n_pix);
        end
        checks++;
        if (px[0] != 159 || py[0] != 150) begin
            errors++;
            $display("FAIL dp_first: got (%0d,%0d) want (159,150)", px[0], py[0]);
        end
        checks++;
        if (px[160] != 319 || py[160] != 0) begin
            errors++;
            $display("FAIL dp_last: got (%0d,%0d) want (319,0)", px[160], py[160]);
        end
        for (int i = 1; i < 161; i++) begin
            if (py[i] > py[i-1] || py[i-1] - py[i] > 1 || px[i] != px[i-1] + 1) mono_ok = 0;
        end
        checks++;
        if (!mono_ok) begin
            errors++;
            $display("FAIL dp_shape: got non-monotonic or non-unit steps want y non-increasing");
        end
    endtask

    task automatic test_back_to_back();
        bit hist [0:29];
        int run1_end = -1, run2_start = -1, run2_len = 0;
        @(negedge clk);
        x0 = 11'd0;
        y0 = 11'd0;
        x1 = 11'd2;
        y1 = 11'd0;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            hist[i] = pixel_valid;
        end
        start = 1'b0;
        for (int i = 1; i < 30; i++) begin
            if (run1_end < 0 && hist[i-1] && !hist[i]) run1_end = i - 1;
            if (run1_end >= 0 && run2_start < 0 && !hist[i-1] && hist[i]) run2_start = i;
        end
        for (int i = 0; i < 30; i++) begin
            if (run2_start >= 0 && i >= run2_start && hist[i] && run2_len == i - run2_start)
                run2_len++;
        end
        checks++;
        if (run1_end < 0 || run2_start - run1_end - 1 != 3) begin
            errors++;
            $display("FAIL b2b_gap: got %0d idle cycles want 3", run2_start - run1_end - 1);
        end
        checks++;
        if (run2_len != 3) begin
            errors++;
            $display("FAIL b2b_len2: got %0d pixels want 3", run2_len);
        end
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_midline();
        int seen = 0;
        int wait_cyc = -1;
        int cnt = 0;
        @(negedge clk);
        x0 = 11'd0;
        y0 = 11'd0;
        x1 = 11'd10;
        y1 = 11'd0;
        start = 1'b1;
        for (int i = 0; i < 20 && seen < 3; i++) begin
            @(negedge clk);
            if (pixel_valid) seen++;
        end
        checks++;
        if (seen != 3 || x !== 11'd2) begin
            errors++;
            $display("FAIL rst_3rd_px: got seen=%0d x=%0d want 3,2", seen, x);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got pv=%b busy=%b done=%b want 0,0,0",
                     pixel_valid, busy, done);
        end
        @(negedge clk);
        checks++;
        if (pixel_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold: got pv=%b want 0", pixel_valid);
        end
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (pixel_valid) begin
                wait_cyc = i;
                break;
            end
        end
        checks++;
        if (wait_cyc < 1 || wait_cyc > 3 || x !== 11'd0 || y !== 11'd0) begin
            errors++;
            $display("FAIL rst_restart: got cycle %0d at (%0d,%0d) want <=3 at (0,0)",
                     wait_cyc, x, y);
        end
        start = 1'b0;
        while (pixel_valid && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 11) begin
            errors++;
            $display("FAIL rst_relen: got %0d pixels want 11", cnt);
        end
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_reversed();
        test_degenerate();
        test_datapath_line();
        test_back_to_back();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
